// File: rtl/ldpc_pkg.sv
// Shared defaults, loader state encoding and saturation bound for the LDPC input path.
package ldpc_pkg;

    localparam int DEF_DATA_WIDTH = 5;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_IN_WIDTH   = 8;
    localparam int DEF_CW_LEN     = 256;

    // state   | meaning
    // IDLE    | waiting for the current write bank to be free
    // LOAD    | accepting LLR samples into the current write bank
    // HANDOFF | codeword complete: mark bank full, start decoder, swap banks
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        HANDOFF = 2'd2
    } loader_state_t;

    // Largest magnitude kept after saturation; range is symmetric so -bound..+bound.
    function automatic int sat_bound(input int dw);
        return (2 ** (dw - 1)) - 1;
    endfunction

    localparam int SAT_BOUND = sat_bound(DEF_DATA_WIDTH);

endpackage

// File: rtl/llr_sat.sv
// Combinational symmetric saturator: narrows a channel LLR and flags clipping.
module llr_sat
    import ldpc_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [IN_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  clip
);

    localparam int BOUND = sat_bound(DATA_WIDTH);
    localparam logic signed [IN_WIDTH-1:0]   POS_IN  = IN_WIDTH'(BOUND);
    localparam logic signed [IN_WIDTH-1:0]   NEG_IN  = IN_WIDTH'(-BOUND);
    localparam logic        [DATA_WIDTH-1:0] POS_OUT = DATA_WIDTH'(BOUND);
    localparam logic        [DATA_WIDTH-1:0] NEG_OUT = DATA_WIDTH'(-BOUND);

    logic signed [IN_WIDTH-1:0] din_s;
    assign din_s = din;

    // Clip to +/-BOUND; the most negative code of DATA_WIDTH is never produced.
    always_comb begin
        dout = din[DATA_WIDTH-1:0];
        clip = 1'b0;
        if (din_s > POS_IN) begin
            dout = POS_OUT;
            clip = 1'b1;
        end else if (din_s < NEG_IN) begin
            dout = NEG_OUT;
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/int_msg_loader.sv
// Ping-pong loader: saturates channel LLRs into two intrinsic RAM banks and hands
// each completed codeword to the decoder, with backpressure while both banks are full.
module int_msg_loader
    import ldpc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int CW_LEN     = DEF_CW_LEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       llr_valid,
    input  logic [IN_WIDTH-1:0]        llr_data,
    output logic                       llr_ready,
    output logic [0:1][ADDR_WIDTH-1:0] ram_address,
    output logic [0:1][DATA_WIDTH-1:0] ram_data_in,
    output logic [0:1]                 ram_we,
    output logic [0:1]                 ram_cs,
    output logic [1:0]                 bank_full,
    output logic                       dec_start,
    output logic                       dec_bank,
    input  logic                       dec_done,
    input  logic                       dec_done_bank,
    output logic [15:0]                sat_count,
    output logic                       err_release
);

    if (CW_LEN < 2 || CW_LEN > 2 ** ADDR_WIDTH) begin : g_bad_cw_len
        $error("int_msg_loader: CW_LEN must lie in 2..2**ADDR_WIDTH");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CW_LEN - 1);

    loader_state_t             state, state_nxt;
    logic                      wr_bank;
    logic [ADDR_WIDTH-1:0]     count;
    logic                      accept;
    logic                      last_beat;
    logic                      handoff;
    logic [DATA_WIDTH-1:0]     sat_data;
    logic                      clip;
    logic [1:0]                bank_full_nxt;
    logic                      err_nxt;

    llr_sat #(
        .IN_WIDTH   (IN_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sat (
        .din  (llr_data),
        .dout (sat_data),
        .clip (clip)
    );

    // llr_ready decodes the state register directly, so it carries no combinational input path.
    assign llr_ready = (state == LOAD);
    assign accept    = llr_valid && llr_ready;
    assign last_beat = (count == LAST_ADDR);
    assign handoff   = (state == HANDOFF);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!bank_full[wr_bank])   state_nxt = LOAD;
            LOAD:    if (accept && last_beat)   state_nxt = HANDOFF;
            HANDOFF:                            state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // Registered RAM write port, word counter, bank pointer and clip counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_cs      <= '0;
            ram_we      <= '0;
            ram_address <= '0;
            ram_data_in <= '0;
            count       <= '0;
            wr_bank     <= 1'b0;
            sat_count   <= '0;
        end else begin
            ram_cs      <= '0;
            ram_we      <= '0;
            ram_address <= '0;
            ram_data_in <= '0;
            if (accept) begin
                ram_cs[wr_bank]      <= 1'b1;
                ram_we[wr_bank]      <= 1'b1;
                ram_address[wr_bank] <= count;
                ram_data_in[wr_bank] <= sat_data;
                count                <= last_beat ? '0 : count + 1'b1;
                if (clip && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
            end
            if (handoff) wr_bank <= ~wr_bank;
        end
    end

    // Bank occupancy: set on handoff, clear on release; a release that cannot apply is an error.
    always_comb begin
        bank_full_nxt = bank_full;
        err_nxt       = 1'b0;
        if (dec_done) begin
            if (bank_full[dec_done_bank] && !(handoff && wr_bank == dec_done_bank))
                bank_full_nxt[dec_done_bank] = 1'b0;
            else
                err_nxt = 1'b1;
        end
        if (handoff) bank_full_nxt[wr_bank] = 1'b1;
    end

    // Occupancy, sticky error flag and decoder start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full   <= '0;
            err_release <= 1'b0;
            dec_start   <= 1'b0;
            dec_bank    <= 1'b0;
        end else begin
            bank_full   <= bank_full_nxt;
            err_release <= err_release | err_nxt;
            dec_start   <= handoff;
            if (handoff) dec_bank <= wr_bank;
        end
    end

endmodule
